mdio_peripheral: RTL

- PHY-side MDIO responder (Clause 22 frames); the opposite end of mdio_controller.
- Watches MDC, MDIO_OUT and MDIO_OE from the controller, decodes each 32-bit frame, and acts on frames whose PHYAD matches.
- Write frames: issues a one-cycle write strobe to a local register file.
- Read frames: drives turnaround and 16 data bits back on MDIO_IN, MSB first.

---
 rtl/mdio_pkg.sv | 71 +++++++
 rtl/mdio_mdc_edge.sv | 32 +++
 rtl/mdio_peripheral.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_pkg
//  Description : Shared constants, header layout, state encoding and the
//                header decode helper for the Clause 22 MDIO peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

   // Frame field codes
   localparam logic [1:0] ST_CODE  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   // Field widths
   localparam int PHYAD_W    = 5;
   localparam int REGAD_W    = 5;
   localparam int DATA_W     = 16;
   localparam int FRAME_BITS = 32;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam int HDR_W      = 2 + PHYAD_W + REGAD_W;

   // Bit positions inside a frame, counted in MDC rising edges
   localparam logic [CNT_W-1:0] BIT_ST1      = CNT_W'(1);
   localparam logic [CNT_W-1:0] BIT_HDR0     = CNT_W'(2);
   localparam logic [CNT_W-1:0] BIT_HDR_LAST = CNT_W'(13);
   localparam logic [CNT_W-1:0] BIT_TA0      = CNT_W'(14);
   localparam logic [CNT_W-1:0] BIT_TA1      = CNT_W'(15);
   localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(FRAME_BITS - 1);

   // Peripheral state encoding
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST    = 3'd1;
   localparam logic [STATE_W-1:0] HDR   = 3'd2;
   localparam logic [STATE_W-1:0] WTA   = 3'd3;
   localparam logic [STATE_W-1:0] WDATA = 3'd4;
   localparam logic [STATE_W-1:0] RTA   = 3'd5;
   localparam logic [STATE_W-1:0] RDATA = 3'd6;
   localparam logic [STATE_W-1:0] SKIP  = 3'd7;

   // Header bits in arrival order: OP first, REGAD last
   typedef struct packed {
      logic [1:0]         op;
      logic [PHYAD_W-1:0] phyad;
      logic [REGAD_W-1:0] regad;
   } mdio_hdr_t;

   typedef enum logic [1:0] {
      ACT_SKIP  = 2'd0,
      ACT_WRITE = 2'd1,
      ACT_READ  = 2'd2
   } mdio_act_t;

   // Decide what a completed header asks of this PHY
   function automatic mdio_act_t hdr_action(input mdio_hdr_t hdr,
                                            input logic [PHYAD_W-1:0] my_addr);
      mdio_act_t act;
      act = ACT_SKIP;
      if (hdr.phyad == my_addr) begin
         if (hdr.op == OP_WRITE) begin
            act = ACT_WRITE;
         end else if (hdr.op == OP_READ) begin
            act = ACT_READ;
         end
      end
      return act;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_mdc_edge.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_mdc_edge
//  Description : Registers MDC in the system clock domain and produces
//                single-cycle rise / fall pulses. MDC is generated
//                synchronously to the system clock, so no synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_mdc_edge (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic mdc_i,
   output logic rise_o,
   output logic fall_o
);

   logic mdc_q;

   // Previous MDC level; cleared in reset so a high MDC looks like a rise later
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mdc_q <= 1'b0;
      end else begin
         mdc_q <= mdc_i;
      end
   end

   assign rise_o = mdc_i & ~mdc_q;
   assign fall_o = ~mdc_i & mdc_q;

endmodule
`default_nettype wire

// File: rtl/mdio_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_peripheral
//  Description : PHY-side Clause 22 MDIO responder. Decodes frames seen on
//                MDC / MDIO_OUT / MDIO_OE, strobes writes into a local
//                register file and returns read data on MDIO_IN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_peripheral
   import mdio_pkg::*;
#(
   parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'b00001
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               MDC,
   input  logic               MDIO_OUT,
   input  logic               MDIO_OE,
   input  logic [DATA_W-1:0]  RD_DATA,
   output logic               MDIO_IN,
   output logic               PHY_OE,
   output logic [REGAD_W-1:0] ADDR,
   output logic [DATA_W-1:0]  WR_DATA,
   output logic               WR_STB,
   output logic               FRAME_DONE
);

   logic               rise;
   logic               fall;

   logic [STATE_W-1:0] state_q,      state_d;
   logic [CNT_W-1:0]   bitcnt_q,     bitcnt_d;
   logic [HDR_W-2:0]   hdr_sr_q,     hdr_sr_d;
   logic [DATA_W-2:0]  rx_sr_q,      rx_sr_d;
   logic [DATA_W-1:0]  tx_sr_q,      tx_sr_d;
   logic [REGAD_W-1:0] addr_q,       addr_d;
   logic [DATA_W-1:0]  wr_data_q,    wr_data_d;
   logic               wr_stb_q,     wr_stb_d;
   logic               frame_done_q, frame_done_d;
   logic               mdio_in_q,    mdio_in_d;
   logic               phy_oe_q,     phy_oe_d;

   // Header including the bit arriving on this rise, and what it requests
   mdio_hdr_t          hdr_next;
   mdio_act_t          hdr_act;

   // Controller frame bits, valid only while it is driving
   logic               ctl_valid;

   mdio_mdc_edge u_mdc_edge (
      .clk_i   (CLK),
      .rst_n_i (RESET),
      .mdc_i   (MDC),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   assign hdr_next  = {hdr_sr_q, MDIO_OUT};
   assign hdr_act   = hdr_action(hdr_next, PHY_ADDR);
   assign ctl_valid = MDIO_OE;

   // State register
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; controller drop-out aborts only the phases it drives
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (rise && ctl_valid && (MDIO_OUT == ST_CODE[1])) begin
               state_d = ST;
            end
         end
         ST: begin
            if (rise) begin
               if (!ctl_valid) begin
                  state_d = IDLE;
               end else if (MDIO_OUT == ST_CODE[0]) begin
                  state_d = HDR;
               end
            end
         end
         HDR: begin
            if (rise) begin
               if (!ctl_valid) begin
                  state_d = IDLE;
               end else if (bitcnt_q == BIT_HDR_LAST) begin
                  unique case (hdr_act)
                     ACT_WRITE: state_d = WTA;
                     ACT_READ:  state_d = RTA;
                     default:   state_d = SKIP;
                  endcase
               end
            end
         end
         WTA: begin
            if (rise) begin
               if (!ctl_valid) begin
                  state_d = IDLE;
               end else if (bitcnt_q == BIT_TA1) begin
                  state_d = WDATA;
               end
            end
         end
         WDATA: begin
            if (rise) begin
               if (!ctl_valid || (bitcnt_q == BIT_LAST)) begin
                  state_d = IDLE;
               end
            end
         end
         RTA: begin
            if (fall && (bitcnt_q == BIT_TA1)) begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            // Counter wraps to zero on rise 31; the next fall ends the frame
            if (fall && (bitcnt_q == '0)) begin
               state_d = IDLE;
            end
         end
         SKIP: begin
            if (rise && (bitcnt_q == BIT_LAST)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values for the current state
   always_comb begin
      bitcnt_d     = bitcnt_q;
      hdr_sr_d     = hdr_sr_q;
      rx_sr_d      = rx_sr_q;
      tx_sr_d      = tx_sr_q;
      addr_d       = addr_q;
      wr_data_d    = wr_data_q;
      wr_stb_d     = 1'b0;
      frame_done_d = 1'b0;
      mdio_in_d    = mdio_in_q;
      phy_oe_d     = phy_oe_q;
      unique case (state_q)
         IDLE: begin
            if (rise && ctl_valid && (MDIO_OUT == ST_CODE[1])) begin
               bitcnt_d = BIT_ST1;
            end
         end
         ST: begin
            if (rise && ctl_valid && (MDIO_OUT == ST_CODE[0])) begin
               bitcnt_d = BIT_HDR0;
            end
         end
         HDR: begin
            if (rise) begin
               if (!ctl_valid) begin
                  bitcnt_d = '0;
               end else begin
                  hdr_sr_d = hdr_next[HDR_W-2:0];
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  if ((bitcnt_q == BIT_HDR_LAST) && (hdr_act != ACT_SKIP)) begin
                     addr_d = hdr_next.regad;
                  end
               end
            end
         end
         WTA: begin
            if (rise) begin
               bitcnt_d = ctl_valid ? (bitcnt_q + CNT_W'(1)) : '0;
            end
         end
         WDATA: begin
            if (rise) begin
               if (!ctl_valid) begin
                  bitcnt_d = '0;
               end else begin
                  rx_sr_d  = {rx_sr_q[DATA_W-3:0], MDIO_OUT};
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  if (bitcnt_q == BIT_LAST) begin
                     wr_data_d    = {rx_sr_q, MDIO_OUT};
                     wr_stb_d     = 1'b1;
                     frame_done_d = 1'b1;
                  end
               end
            end
         end
         RTA: begin
            // ADDR settled one rise earlier, so RD_DATA is valid here
            if (rise && (bitcnt_q == BIT_TA0)) begin
               tx_sr_d  = RD_DATA;
               bitcnt_d = BIT_TA1;
            end else if (fall && (bitcnt_q == BIT_TA1)) begin
               phy_oe_d  = 1'b1;
               mdio_in_d = 1'b0;
            end
         end
         RDATA: begin
            if (rise) begin
               bitcnt_d = bitcnt_q + CNT_W'(1);
            end else if (fall) begin
               if (bitcnt_q == '0) begin
                  phy_oe_d     = 1'b0;
                  mdio_in_d    = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  mdio_in_d = tx_sr_q[DATA_W-1];
                  tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         SKIP: begin
            if (rise) begin
               bitcnt_d = bitcnt_q + CNT_W'(1);
            end
         end
         default: begin
            bitcnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         bitcnt_q     <= '0;
         hdr_sr_q     <= '0;
         rx_sr_q      <= '0;
         tx_sr_q      <= '0;
         addr_q       <= '0;
         wr_data_q    <= '0;
         wr_stb_q     <= 1'b0;
         frame_done_q <= 1'b0;
         mdio_in_q    <= 1'b0;
         phy_oe_q     <= 1'b0;
      end else begin
         bitcnt_q     <= bitcnt_d;
         hdr_sr_q     <= hdr_sr_d;
         rx_sr_q      <= rx_sr_d;
         tx_sr_q      <= tx_sr_d;
         addr_q       <= addr_d;
         wr_data_q    <= wr_data_d;
         wr_stb_q     <= wr_stb_d;
         frame_done_q <= frame_done_d;
         mdio_in_q    <= mdio_in_d;
         phy_oe_q     <= phy_oe_d;
      end
   end

   // Bus drive is gated by reset so a mid-read reset releases the line at once
   assign MDIO_IN    = mdio_in_q & RESET;
   assign PHY_OE     = phy_oe_q & RESET;
   assign ADDR       = addr_q;
   assign WR_DATA    = wr_data_q;
   assign WR_STB     = wr_stb_q;
   assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire
